// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: store lane alignment, misalign flag, EX forwarding tap.
// Optional EXMEM_STAT_EN adds saturating stall/bubble counters.
module ex_mem_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
`ifdef EXMEM_STAT_EN
  ,
  parameter int STAT_W     = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [XLEN-1:0]       alu_res_i,
  input  logic [XLEN-1:0]       store_data_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  reg_we_i,
  input  logic                  mem_we_i,
  input  logic                  mem_re_i,
  input  logic [1:0]            mem_size_i,
  output logic                  valid_o,
  output logic [XLEN-1:0]       alu_res_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic [3:0]            be_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  reg_we_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  output logic [1:0]            mem_size_o,
  output logic                  misalign_o,
  output logic                  fwd_en_o,
  output logic [REG_ADDR_W-1:0] fwd_rd_o,
  output logic [XLEN-1:0]       fwd_data_o
`ifdef EXMEM_STAT_EN
  ,
  output logic [STAT_W-1:0]     stall_cnt_o,
  output logic [STAT_W-1:0]     bubble_cnt_o
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       alu_res;
    logic [XLEN-1:0]       wdata;
    logic [3:0]            be;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_we;
    logic                  mem_we;
    logic                  mem_re;
    logic [1:0]            size;
    logic                  misalign;
  } ex_mem_t;

  ex_mem_t         q, nxt;
  logic [1:0]      a;
  logic [XLEN-1:0] lane_wdata;
  logic [3:0]      lane_be;
  logic            lane_bad;
  logic            is_mem;
  logic            bad;
  logic            bubble;

  always_comb begin
    a          = alu_res_i[1:0];
    lane_wdata = store_data_i;
    lane_be    = 4'b0000;
    lane_bad   = 1'b0;
    unique case (mem_size_i)
      2'b00: begin
        lane_wdata = {4{store_data_i[7:0]}};
        lane_be    = 4'b0001 << a;
      end
      2'b01: begin
        lane_wdata = {2{store_data_i[15:0]}};
        lane_be    = a[1] ? 4'b1100 : 4'b0011;
        lane_bad   = a[0];
      end
      2'b10: begin
        lane_be  = 4'b1111;
        lane_bad = |a;
      end
      default: lane_bad = 1'b1;
    endcase
  end

  // Misalignment only matters for real memory ops; it cancels the access.
  always_comb begin
    is_mem       = mem_we_i | mem_re_i;
    bad          = is_mem & lane_bad;
    nxt          = '0;
    nxt.valid    = 1'b1;
    nxt.alu_res  = alu_res_i;
    nxt.wdata    = lane_wdata;
    nxt.be       = (is_mem & ~bad) ? lane_be : 4'b0000;
    nxt.rd       = rd_i;
    nxt.reg_we   = reg_we_i;
    nxt.mem_we   = mem_we_i & ~bad;
    nxt.mem_re   = mem_re_i & ~bad;
    nxt.size     = mem_size_i;
    nxt.misalign = bad;
  end

  assign bubble = flush_i | (~stall_i & ~valid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         q <= '0;
    else if (bubble)   q <= '0;
    else if (!stall_i) q <= nxt;
  end

  assign valid_o    = q.valid;
  assign alu_res_o  = q.alu_res;
  assign wdata_o    = q.wdata;
  assign be_o       = q.be;
  assign rd_o       = q.rd;
  assign reg_we_o   = q.reg_we;
  assign mem_we_o   = q.mem_we;
  assign mem_re_o   = q.mem_re;
  assign mem_size_o = q.size;
  assign misalign_o = q.misalign;

  // Load data is not available yet, so loads never forward from here.
  assign fwd_en_o   = q.valid & q.reg_we & ~q.mem_re & (q.rd != '0);
  assign fwd_rd_o   = q.rd;
  assign fwd_data_o = q.alu_res;

`ifdef EXMEM_STAT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (stall_i && !flush_i && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (bubble && !(&bubble_cnt_o))
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg.
// Expected register images are queued at drive time and popped after each edge.
module tb_ex_mem_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i, valid_i;
  logic [31:0] alu_res_i, store_data_i;
  logic [4:0]  rd_i;
  logic        reg_we_i, mem_we_i, mem_re_i;
  logic [1:0]  mem_size_i;
  logic        valid_o;
  logic [31:0] alu_res_o, wdata_o;
  logic [3:0]  be_o;
  logic [4:0]  rd_o;
  logic        reg_we_o, mem_we_o, mem_re_o;
  logic [1:0]  mem_size_o;
  logic        misalign_o, fwd_en_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;
`ifdef EXMEM_STAT_EN
  logic [15:0] stall_cnt_o, bubble_cnt_o;
`endif

  ex_mem_reg dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .alu_res_i(alu_res_i),
    .store_data_i(store_data_i), .rd_i(rd_i),
    .reg_we_i(reg_we_i), .mem_we_i(mem_we_i),
    .mem_re_i(mem_re_i), .mem_size_i(mem_size_i),
    .valid_o(valid_o), .alu_res_o(alu_res_o),
    .wdata_o(wdata_o), .be_o(be_o), .rd_o(rd_o),
    .reg_we_o(reg_we_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .mem_size_o(mem_size_o),
    .misalign_o(misalign_o), .fwd_en_o(fwd_en_o),
    .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o)
`ifdef EXMEM_STAT_EN
    ,
    .stall_cnt_o(stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef logic [117:0] img_t;

  img_t obs;
  assign obs = {valid_o, alu_res_o, wdata_o, be_o, rd_o,
                reg_we_o, mem_we_o, mem_re_o, mem_size_o,
                misalign_o, fwd_en_o, fwd_rd_o, fwd_data_o};

  img_t exp_q[$];
  img_t cur;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic img_t mdl(
    input logic v, input logic [31:0] alu, input logic [31:0] sd,
    input logic [4:0] rd, input logic rwe, input logic mwe,
    input logic mre, input logic [1:0] sz);
    logic [31:0] wd;
    logic [3:0]  be;
    logic        bad, mem, fe;
    if (!v) return '0;
    wd  = sd;
    be  = 4'h0;
    bad = 1'b0;
    case (sz)
      2'd0: begin
        wd = {4{sd[7:0]}};
        case (alu[1:0])
          2'd0: be = 4'b0001;
          2'd1: be = 4'b0010;
          2'd2: be = 4'b0100;
          default: be = 4'b1000;
        endcase
      end
      2'd1: begin
        wd  = {2{sd[15:0]}};
        be  = (alu[1:0] >= 2'd2) ? 4'b1100 : 4'b0011;
        bad = alu[0];
      end
      2'd2: begin
        be  = 4'b1111;
        bad = (alu[1:0] != 2'd0);
      end
      default: bad = 1'b1;
    endcase
    mem = mwe | mre;
    bad = bad & mem;
    if (!mem || bad) be = 4'h0;
    fe = rwe && !(mre && !bad) && rd != 5'd0;
    return {1'b1, alu, wd, be, rd, rwe, mwe & ~bad, mre & ~bad,
            sz, bad, fe, rd, alu};
  endfunction

  task automatic drive(
    input logic v, input logic [31:0] alu, input logic [31:0] sd,
    input logic [4:0] rd, input logic rwe, input logic mwe,
    input logic mre, input logic [1:0] sz,
    input logic st, input logic fl);
    valid_i = v; alu_res_i = alu; store_data_i = sd; rd_i = rd;
    reg_we_i = rwe; mem_we_i = mwe; mem_re_i = mre; mem_size_i = sz;
    stall_i = st; flush_i = fl;
    if (fl)      cur = '0;
    else if (st) cur = cur;
    else         cur = mdl(v, alu, sd, rd, rwe, mwe, mre, sz);
    exp_q.push_back(cur);
  endtask

  task automatic async_reset();
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    cur = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    img_t e;
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_init obs=%h exp=0", obs);
    end
    rst_i = 1'b0;
    cur = '0;
    drive(1, 32'hDEAD_BEEF, 32'h0, 5'd9, 1, 0, 0, 2'd2, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_preload obs=%h exp=%h", obs, e);
    end
    #2;
    rst_i = 1'b1;
    #1;
    n_vec++;
    if (obs !== '0 || fwd_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async obs=%h exp=0", obs);
    end
    rst_i = 1'b0;
    cur = '0;
    exp_q.delete();
    #1;
  endtask

  task automatic test_or_forward();
    img_t e;
    drive(1, 32'hFFFF_5678, 32'h0, 5'd5, 1, 0, 0, 2'd2, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL or_fwd obs=%h exp=%h", obs, e);
    end
    n_vec++;
    if (alu_res_o !== 32'hFFFF_5678 || fwd_en_o !== 1'b1 ||
        fwd_rd_o !== 5'd5 || be_o !== 4'b0000) begin
      n_err++;
      $display("FAIL or_fwd_fields res=%h en=%b rd=%0d be=%b exp FFFF5678/1/5/0000",
               alu_res_o, fwd_en_o, fwd_rd_o, be_o);
    end
  endtask

  task automatic test_store_byte();
    img_t e;
    drive(1, 32'h0000_1003, 32'h1234_56AB, 5'd0, 0, 1, 0, 2'd0, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL store_byte obs=%h exp=%h", obs, e);
    end
    n_vec++;
    if (wdata_o !== 32'hABAB_ABAB || be_o !== 4'b1000 || misalign_o !== 1'b0) begin
      n_err++;
      $display("FAIL store_byte_fields wd=%h be=%b mis=%b exp ABABABAB/1000/0",
               wdata_o, be_o, misalign_o);
    end
  endtask

  task automatic test_misalign();
    img_t e;
    drive(1, 32'h0000_0002, 32'h0, 5'd4, 1, 0, 1, 2'd2, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (misalign_o !== 1'b1 || mem_re_o !== 1'b0 || be_o !== 4'b0000 ||
        reg_we_o !== 1'b1 || obs !== e) begin
      n_err++;
      $display("FAIL mis_word obs=%h exp=%h", obs, e);
    end
    drive(1, 32'h0000_2002, 32'hCAFE_1357, 5'd0, 0, 1, 0, 2'd1, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (be_o !== 4'b1100 || wdata_o !== 32'h1357_1357 ||
        misalign_o !== 1'b0 || mem_we_o !== 1'b1 || obs !== e) begin
      n_err++;
      $display("FAIL half_hi obs=%h exp=%h", obs, e);
    end
    drive(1, 32'h0000_0000, 32'h0, 5'd0, 0, 1, 0, 2'd3, 0, 0);
    @(posedge clk_i);
    #1;
    exp_q.pop_front();
    n_vec++;
    if (misalign_o !== 1'b1 || mem_we_o !== 1'b0 || be_o !== 4'b0000) begin
      n_err++;
      $display("FAIL size_rsvd mis=%b we=%b be=%b exp 1/0/0000",
               misalign_o, mem_we_o, be_o);
    end
    drive(1, 32'h0000_0003, 32'h0, 5'd6, 1, 0, 0, 2'd3, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (misalign_o !== 1'b0 || be_o !== 4'b0000 || obs !== e) begin
      n_err++;
      $display("FAIL nonmem_rsvd obs=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_align_sweep();
    img_t e;
    for (int sz = 0; sz < 3; sz++) begin
      for (int off = 0; off < 4; off++) begin
        drive(1, 32'h0000_4000 | 32'(off), $urandom, 5'd0, 0,
              1, 0, 2'(sz), 0, 0);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL sweep sz=%0d off=%0d obs=%h exp=%h", sz, off, obs, e);
        end
      end
    end
  endtask

  task automatic test_stall_flush();
    img_t e;
    async_reset();
    drive(1, 32'h0000_0777, 32'h0, 5'd7, 1, 0, 0, 2'd2, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL stall_load obs=%h exp=%h", obs, e);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, $urandom, 5'(i + 10), 1, 1, 0, 2'd0, 1, 0);
      @(posedge clk_i);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e || rd_o !== 5'd7 || fwd_en_o !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold%0d obs=%h exp=%h", i, obs, e);
      end
    end
    drive(1, 32'h1, 32'h1, 5'd8, 1, 0, 0, 2'd2, 1, 1);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e || valid_o !== 1'b0 || fwd_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_over_stall obs=%h exp=%h", obs, e);
    end
`ifdef EXMEM_STAT_EN
    n_vec++;
    if (stall_cnt_o !== 16'd3 || bubble_cnt_o !== 16'd1) begin
      n_err++;
      $display("FAIL stat_cnt stall=%0d bubble=%0d exp 3/1",
               stall_cnt_o, bubble_cnt_o);
    end
`endif
    drive(0, 32'h55, 32'h0, 5'd2, 1, 1, 1, 2'd0, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL invalid_bubble obs=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_fwd_block();
    img_t e;
    drive(1, 32'h0000_0123, 32'h0, 5'd0, 1, 0, 0, 2'd2, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (fwd_en_o !== 1'b0 || obs !== e) begin
      n_err++;
      $display("FAIL fwd_rd0 en=%b exp=0", fwd_en_o);
    end
    drive(1, 32'h0000_0100, 32'h0, 5'd3, 1, 0, 1, 2'd2, 0, 0);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (fwd_en_o !== 1'b0 || mem_re_o !== 1'b1 || obs !== e) begin
      n_err++;
      $display("FAIL fwd_load en=%b re=%b exp 0/1", fwd_en_o, mem_re_o);
    end
  endtask

  task automatic test_back_to_back();
    img_t e;
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom, $urandom,
            5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), $urandom_range(3, 0) == 0,
            $urandom_range(7, 0) == 0);
      @(posedge clk_i);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL b2b%0d obs=%h exp=%h", i, obs, e);
      end
    end
  endtask

  initial begin
    cur = '0;
    test_reset();
    test_or_forward();
    test_store_byte();
    test_misalign();
    test_align_sweep();
    test_stall_flush();
    test_fwd_block();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
EX/MEM pipeline register of the RV32I core. It sits directly downstream of the execute-stage ALU (whose logic unit includes the 32-bit OR gate) and captures the ALU result and the store operand each cycle. It also pre-computes store byte-enables and lane-aligned store data, flags misaligned accesses, and drives the EX->EX forwarding tap. It supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
XLEN, 32, datapath width; only 32 is supported by the alignment logic.
REG_ADDR_W, 5, destination register index width.
STAT_W, 16, counter width; used only when EXMEM_STAT_EN is defined.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
stall_i  in  1  hold current contents
flush_i  in  1  insert bubble
valid_i  in  1  EX stage holds a real instruction
alu_res_i  in  XLEN  ALU result, or memory address for loads/stores
store_data_i  in  XLEN  rs2 value for stores
rd_i  in  REG_ADDR_W  destination register
reg_we_i  in  1  register write-back enable
mem_we_i  in  1  store
mem_re_i  in  1  load
mem_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
valid_o  out  1  registered valid
alu_res_o  out  XLEN  registered ALU result / address
wdata_o  out  XLEN  lane-aligned store data
be_o  out  4  store byte enables
rd_o  out  REG_ADDR_W  registered rd
reg_we_o, mem_we_o, mem_re_o  out  1 each  registered controls
mem_size_o  out  2  registered size
misalign_o  out  1  misaligned or reserved-size access captured
fwd_en_o  out  1  forwarding tap valid
fwd_rd_o  out  REG_ADDR_W  forwarding destination
fwd_data_o  out  XLEN  forwarding value

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset: all registered outputs are 0, including valid_o, controls, data, be_o and misalign_o.
- Update priority on each rising edge: rst_i > flush_i > stall_i > load.
- Flush: load a bubble. valid_o, reg_we_o, mem_we_o, mem_re_o, misalign_o and be_o become 0; data fields become 0. When flush_i and stall_i are both 1, flush wins.
- Stall: every register holds. The forwarding tap keeps reflecting the held contents.
- Load with valid_i=0: same result as a flush (bubble). Input controls are ignored.
- Load with valid_i=1: capture all inputs with 1-cycle latency. Alignment uses a = alu_res_i[1:0]:
  - byte: wdata = {4{sd[7:0]}}, be = 4'b0001 << a.
  - half: wdata = {2{sd[15:0]}}; be = 0011 if a=00, 1100 if a=10; a[0]=1 is misaligned.
  - word: wdata = sd, be = 1111; a != 00 is misaligned.
  - size 11: misaligned.
- Misaligned handling: misalign_o=1 only when mem_we_i or mem_re_i is set. A misaligned access captures mem_we_o=0, mem_re_o=0 and be_o=0; reg_we_o is still captured as given. Non-memory instructions force misalign_o=0 and be_o=0.
- Forwarding (combinational from the registers):
  - fwd_en_o = valid_o & reg_we_o & ~mem_re_o & (rd_o != 0).
  - fwd_rd_o = rd_o; fwd_data_o = alu_res_o.
  - Loads never forward from this stage.
- Reset asserted mid-operation clears the registers immediately, with no clock needed. The first capture after release happens on the first rising edge with rst_i=0.

Optional Feature:
EXMEM_STAT_EN.
- Defined: adds outputs stall_cnt_o and bubble_cnt_o, each STAT_W bits.
  - stall_cnt_o increments on each edge where stall_i=1 and flush_i=0.
  - bubble_cnt_o increments on each edge where a bubble is loaded (flush, or valid_i=0 while not stalled).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle after loading data -> all outputs 0 before the next edge; fwd_en_o=0.
- OR result forward: valid_i=1, alu_res_i=0xFFFF5678, rd_i=5, reg_we_i=1, no mem -> next cycle alu_res_o=0xFFFF5678, fwd_en_o=1, fwd_rd_o=5, be_o=0.
- Store byte: mem_we_i=1, size 00, alu_res_i=0x00001003, store_data_i=0x123456AB -> wdata_o=0xABABABAB, be_o=1000, misalign_o=0.
- Misaligned word: mem_re_i=1, size 10, alu_res_i=0x00000002 -> misalign_o=1, mem_re_o=0, be_o=0; store half at address 0x...2 -> be_o=1100, wdata_o={2{sd[15:0]}}.
- Stall then flush: load rd=7; stall_i=1 for 3 cycles -> outputs held; then flush_i=1 with stall_i=1 -> valid_o=0, fwd_en_o=0. With EXMEM_STAT_EN: stall_cnt_o=3, bubble_cnt_o=1.
- rd_i=0 with reg_we_i=1 -> fwd_en_o=0. Load to rd=3 -> fwd_en_o=0.
